// File: rtl/asrm_bus_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter.
//   asrm_state_t : arbiter FSM states (IDLE, ACCESS, ACK)
//   GNT_M0/GNT_M1: bit positions of each master inside the one-hot grant bus
//   OWN_M0/OWN_M1: single-bit owner encoding used by the round-robin picker
//   CNT_W        : width of the wait-state counter (wait_states is 0..15)
package asrm_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } asrm_state_t;

  localparam int   GNT_M0 = 0;
  localparam int   GNT_M1 = 1;
  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;
  localparam int   CNT_W  = 4;

  // One-hot grant vector for a given owner.
  function automatic logic [1:0] grant_onehot(input logic owner);
    logic [1:0] g;
    g = '0;
    if (owner == OWN_M1) g[GNT_M1] = 1'b1;
    else                 g[GNT_M0] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/asrm_rr_pick.sv
// Two-request round-robin picker with its last_grant register.
//   clk, reset : clock, synchronous active-low reset
//   req0, req1 : request from master 0 / master 1
//   take       : a grant is being issued this cycle; remember the winner
//   pick       : winner (OWN_M0 / OWN_M1), valid when any_req is high
//   any_req    : at least one request is pending
module asrm_rr_pick
  import asrm_bus_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic pick,
  output logic any_req
);

  logic last_grant;

  // On a tie the master that did not win last time gets the bus.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1)  pick = (last_grant == OWN_M1) ? OWN_M0 : OWN_M1;
    else if (req1)     pick = OWN_M1;
    else               pick = OWN_M0;
  end

  // Reset to m1 so that m0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset)    last_grant <= OWN_M1;
    else if (take) last_grant <= pick;
  end

endmodule

// File: rtl/asrm_bus_arbiter.sv
// Two-master arbiter in front of a single-port RAM.
// Each access runs IDLE -> ACCESS (wait_states+1 cycles) -> ACK (1 cycle).
//   clk, reset                 : clock, synchronous active-low reset
//   m0_*/m1_*  req/addr/wdata/we: master requests (m0 = CPU, m1 = DMA)
//   m0_ready, m1_ready         : one-cycle completion strobe in ACK
//   rdata                      : last read data, shared by both masters
//   grant                      : one-hot owner (bit0 m0, bit1 m1), 00 in IDLE
//   ram_addr/ram_wdata/ram_we  : RAM side, all zero outside ACCESS
//   ram_rdata                  : RAM read data, sampled in the last ACCESS cycle
module asrm_bus_arbiter
  import asrm_bus_arbiter_pkg::*;
#(
  parameter int wordsize    = 16,
  parameter int wait_states = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m1_req,
  input  logic [wordsize-1:0] m0_addr,
  input  logic [wordsize-1:0] m1_addr,
  input  logic [wordsize-1:0] m0_wdata,
  input  logic [wordsize-1:0] m1_wdata,
  input  logic                m0_we,
  input  logic                m1_we,
  output logic                m0_ready,
  output logic                m1_ready,
  output logic [wordsize-1:0] rdata,
  output logic [1:0]          grant,
  output logic [wordsize-1:0] ram_addr,
  output logic [wordsize-1:0] ram_wdata,
  output logic                ram_we,
  input  logic [wordsize-1:0] ram_rdata
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(wait_states);

  asrm_state_t         state, state_nxt;
  logic [CNT_W-1:0]    wait_cnt;
  logic                owner;
  logic [wordsize-1:0] lat_addr;
  logic [wordsize-1:0] lat_wdata;
  logic                lat_we;
  logic                pick;
  logic                any_req;
  logic                take;
  logic                first_cycle;
  logic                last_cycle;

  asrm_rr_pick u_rr_pick (
    .clk     (clk),
    .reset   (reset),
    .req0    (m0_req),
    .req1    (m1_req),
    .take    (take),
    .pick    (pick),
    .any_req (any_req)
  );

  assign take        = (state == ST_IDLE) && any_req;
  // The counter starts at wait_states and counts down, so the first ACCESS
  // cycle is the one where it still holds its load value.
  assign first_cycle = (wait_cnt == WAIT_INIT);
  assign last_cycle  = (wait_cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = '0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        grant     = grant_onehot(owner);
        ram_addr  = lat_addr;
        ram_wdata = lat_wdata;
        ram_we    = lat_we && first_cycle;
        if (last_cycle) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        grant     = grant_onehot(owner);
        m0_ready  = (owner == OWN_M0);
        m1_ready  = (owner == OWN_M1);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control state: wait counter, owner, read-data capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
      owner    <= OWN_M0;
      rdata    <= '0;
    end else begin
      if (take) begin
        wait_cnt <= WAIT_INIT;
        owner    <= pick;
      end else if ((state == ST_ACCESS) && !last_cycle) begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end
      if ((state == ST_ACCESS) && last_cycle && !lat_we) rdata <= ram_rdata;
    end
  end

  // Winner's request is frozen at grant; later master input changes are ignored.
  always_ff @(posedge clk) begin
    if (take) begin
      lat_addr  <= (pick == OWN_M1) ? m1_addr  : m0_addr;
      lat_wdata <= (pick == OWN_M1) ? m1_wdata : m0_wdata;
      lat_we    <= (pick == OWN_M1) ? m1_we    : m0_we;
    end
  end

endmodule
